// File: rtl/calendar_key_controller.sv
// Calendar set-mode sequencer driven by decoded keyboard release events.
// Enter opens an edit pass YY -> MO -> DD -> HH -> MM. Each field is a two-digit BCD buffer that
// digits shift into. Enter validates the field and the last Enter pulses set_load for one cycle.
// Space toggles run while idle. Backspace, Escape and an idle timeout navigate or abort the edit.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   scancode, released  key code (bit 8 = extended, ignored) and asynchronous release level
//   cur_yy..cur_mm      current calendar values, snapshotted when editing starts
//   set_load, set_*     one-cycle load strobe and the values to load
//   field, edit         active field (0 idle, 1..5 YY..MM) and edit-mode flag
//   run, key_err        calendar run enable, one-cycle pulse on a rejected Enter
module calendar_key_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] scancode,
  input  logic       released,
  input  logic [6:0] cur_yy,
  input  logic [3:0] cur_mo,
  input  logic [4:0] cur_dd,
  input  logic [4:0] cur_hh,
  input  logic [5:0] cur_mm,
  output logic       set_load,
  output logic [6:0] set_yy,
  output logic [3:0] set_mo,
  output logic [4:0] set_dd,
  output logic [4:0] set_hh,
  output logic [5:0] set_mm,
  output logic [2:0] field,
  output logic       edit,
  output logic       run,
  output logic       key_err
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  // Encodings 1..5 double as the field number and, minus one, as the buffer index.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StYy     = 3'd1,
    StMo     = 3'd2,
    StDd     = 3'd3,
    StHh     = 3'd4,
    StMm     = 3'd5,
    StCommit = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic            s1_q, s2_q;
  logic            run_q, run_d, run_saved_q, run_saved_d;
  logic            key_err_q, key_err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      tens_q [5];
  logic [3:0]      tens_d [5];
  logic [3:0]      ones_q [5];
  logic [3:0]      ones_d [5];
  logic [6:0]      snap_q [5];
  logic [6:0]      snap_d [5];
  logic [6:0]      set_yy_q, set_yy_d;
  logic [3:0]      set_mo_q, set_mo_d;
  logic [4:0]      set_dd_q, set_dd_d, set_hh_q, set_hh_d;
  logic [5:0]      set_mm_q, set_mm_d;

  logic       ev, key_ev;
  logic       is_digit, is_enter, is_space, is_bksp, is_esc;
  logic [2:0] ci;
  logic [6:0] val [5];
  logic [6:0] cur_arr [5];
  logic [6:0] field_val;
  logic       fld_ok, abort;

  function automatic logic [6:0] bcd_val(input logic [3:0] t, input logic [3:0] o);
    return 7'(t) * 7'd10 + 7'(o);
  endfunction

  function automatic logic [3:0] to_tens(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] to_ones(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  function automatic logic [4:0] dim(input logic [6:0] mo, input logic [6:0] yy);
    case (mo)
      7'd4, 7'd6, 7'd9, 7'd11: return 5'd30;
      7'd2:                    return ((yy % 7'd4) == 7'd0) ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  // Rising edge of the synchronised release level marks one key event.
  assign ev     = s1_q & ~s2_q;
  assign key_ev = ev & ~scancode[8];

  assign is_digit = (scancode[7:0] >= 8'h30) && (scancode[7:0] <= 8'h39);
  assign is_enter = scancode[7:0] == 8'h0D;
  assign is_space = scancode[7:0] == 8'h20;
  assign is_bksp  = scancode[7:0] == 8'h08;
  assign is_esc   = scancode[7:0] == 8'h1B;

  assign cur_arr[0] = cur_yy;
  assign cur_arr[1] = {3'b000, cur_mo};
  assign cur_arr[2] = {2'b00, cur_dd};
  assign cur_arr[3] = {2'b00, cur_hh};
  assign cur_arr[4] = {1'b0, cur_mm};

  assign edit      = (state_q >= StYy) && (state_q <= StMm);
  assign field     = edit ? state_q : 3'd0;
  assign ci        = edit ? 3'(state_q) - 3'd1 : 3'd0;
  assign field_val = val[ci];

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      val[i] = bcd_val(tens_q[i], ones_q[i]);
    end
  end

  always_comb begin
    fld_ok = 1'b0;
    case (state_q)
      StYy:    fld_ok = field_val <= 7'd99;
      StMo:    fld_ok = (field_val >= 7'd1) && (field_val <= 7'd12);
      StDd:    fld_ok = (field_val >= 7'd1) && (field_val <= {2'b00, dim(val[1], val[0])});
      StHh:    fld_ok = field_val <= 7'd23;
      StMm:    fld_ok = field_val <= 7'd59;
      default: fld_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    run_saved_d = run_saved_q;
    key_err_d   = 1'b0;
    cnt_d       = '0;
    tens_d      = tens_q;
    ones_d      = ones_q;
    snap_d      = snap_q;
    set_yy_d    = set_yy_q;
    set_mo_d    = set_mo_q;
    set_dd_d    = set_dd_q;
    set_hh_d    = set_hh_q;
    set_mm_d    = set_mm_q;
    abort       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_ev && is_space) begin
          run_d = ~run_q;
        end else if (key_ev && is_enter) begin
          for (int i = 0; i < 5; i++) begin
            snap_d[i] = cur_arr[i];
            tens_d[i] = to_tens(cur_arr[i]);
            ones_d[i] = to_ones(cur_arr[i]);
          end
          run_saved_d = run_q;
          run_d       = 1'b0;
          state_d     = StYy;
        end
      end
      StYy, StMo, StDd, StHh, StMm: begin
        // A key event always restarts the idle count, even when it lands on the expiry cycle.
        if (key_ev) begin
          if (is_digit) begin
            tens_d[ci] = ones_q[ci];
            ones_d[ci] = scancode[3:0];
          end else if (is_enter) begin
            if (!fld_ok) begin
              key_err_d  = 1'b1;
              tens_d[ci] = to_tens(snap_q[ci]);
              ones_d[ci] = to_ones(snap_q[ci]);
            end else if (state_q == StMm) begin
              // Outputs are loaded on entry so they are valid while set_load is high.
              state_d  = StCommit;
              set_yy_d = val[0];
              set_mo_d = val[1][3:0];
              set_dd_d = val[2][4:0];
              set_hh_d = val[3][4:0];
              set_mm_d = val[4][5:0];
            end else begin
              state_d = state_e'(3'(state_q) + 3'd1);
            end
          end else if (is_bksp) begin
            if (state_q == StYy) abort = 1'b1;
            else state_d = state_e'(3'(state_q) - 3'd1);
          end else if (is_esc) begin
            abort = 1'b1;
          end
        end else if (cnt_q == CntLast) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (abort) begin
          state_d = StIdle;
          run_d   = run_saved_q;
        end
      end
      StCommit: begin
        state_d = StIdle;
        run_d   = run_saved_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= StIdle;
      run_q       <= 1'b0;
      run_saved_q <= 1'b0;
      key_err_q   <= 1'b0;
      cnt_q       <= '0;
      tens_q      <= '{default: '0};
      ones_q      <= '{default: '0};
      snap_q      <= '{default: '0};
      set_yy_q    <= 7'd0;
      set_mo_q    <= 4'd1;
      set_dd_q    <= 5'd1;
      set_hh_q    <= 5'd0;
      set_mm_q    <= 6'd0;
    end else begin
      s1_q        <= released;
      s2_q        <= s1_q;
      state_q     <= state_d;
      run_q       <= run_d;
      run_saved_q <= run_saved_d;
      key_err_q   <= key_err_d;
      cnt_q       <= cnt_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      snap_q      <= snap_d;
      set_yy_q    <= set_yy_d;
      set_mo_q    <= set_mo_d;
      set_dd_q    <= set_dd_d;
      set_hh_q    <= set_hh_d;
      set_mm_q    <= set_mm_d;
    end
  end

  assign set_load = state_q == StCommit;
  assign set_yy   = set_yy_q;
  assign set_mo   = set_mo_q;
  assign set_dd   = set_dd_q;
  assign set_hh   = set_hh_q;
  assign set_mm   = set_mm_q;
  assign run      = run_q;
  assign key_err  = key_err_q;

endmodule
